// File: rtl/wb_burst_slave.sv
// rtl/wb_burst_slave.sv - Wishbone B4 burst slave: config registers, STATUS and TX/RX FIFO windows

module wb_burst_slave_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [DW-1:0]          i_dat,
    input  logic                   i_pop,
    output logic [DW-1:0]          o_head,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_cnt;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_cnt == (AW+1)'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_head  = r_mem[r_rp];
    assign o_count = r_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
            if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
            else if (w_pop && !w_push) r_cnt <= r_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= i_dat;
    end
endmodule

module wb_burst_slave #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDRESS = '0,
    parameter int                    NUM_REGS     = 8,
    parameter int                    FIFO_DEPTH   = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ADDR_WIDTH-1:0]          adr_m2s,
    input  logic [DATA_WIDTH-1:0]          dat_m2s,
    output logic [DATA_WIDTH-1:0]          dat_s2m,
    input  logic                           we_m2s,
    input  logic                           cyc_m2s,
    input  logic                           stb_m2s,
    input  logic [2:0]                     cti_m2s,
    input  logic [1:0]                     bte_m2s,
    output logic                           ack_s2m,
    output logic                           err_s2m,
    output logic                           rty_s2m,
    output logic [NUM_REGS*DATA_WIDTH-1:0] cfg_o,
    output logic [DATA_WIDTH-1:0]          tx_dat,
    output logic                           tx_valid,
    input  logic                           tx_ready,
    input  logic [DATA_WIDTH-1:0]          rx_dat,
    input  logic                           rx_valid,
    output logic                           rx_ready
);
    localparam int BYTE_SHIFT = $clog2(DATA_WIDTH / 8);
    localparam int CW         = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_WIDTH-1:0] FIFO_OFF = ADDR_WIDTH'(NUM_REGS);
    localparam logic [ADDR_WIDTH-1:0] STAT_OFF = ADDR_WIDTH'(NUM_REGS + 1);

    typedef enum logic {S_IDLE, S_RESP} state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_WIDTH-1:0] r_off;
    logic [ADDR_WIDTH-1:0] w_next_off;
    logic                  r_below;
    logic                  w_next_below;
    logic [ADDR_WIDTH-1:0] w_cur_off;
    logic                  w_cur_below;
    logic [ADDR_WIDTH-1:0] w_wrap_mask;
    logic [ADDR_WIDTH-1:0] w_inc_off;
    logic [DATA_WIDTH-1:0] r_cfg [NUM_REGS];
    logic [DATA_WIDTH-1:0] w_status;
    logic [DATA_WIDTH-1:0] w_rx_head;
    logic [CW-1:0]         w_tx_count;
    logic [CW-1:0]         w_rx_count;
    logic                  w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
    logic                  w_is_reg, w_is_fifo, w_is_stat;
    logic                  w_err_c, w_rty_c, w_beat;
    logic                  w_wr, w_tx_push, w_rx_pop;

    // Offsets below the base are flagged separately so the subtraction wrap cannot alias a mapped offset.
    assign w_cur_below = (adr_m2s < BASE_ADDRESS);
    assign w_cur_off   = (adr_m2s - BASE_ADDRESS) >> BYTE_SHIFT;

    assign w_is_reg  = !r_below && (r_off < FIFO_OFF);
    assign w_is_fifo = !r_below && (r_off == FIFO_OFF);
    assign w_is_stat = !r_below && (r_off == STAT_OFF);
    assign w_err_c   = !(w_is_reg || w_is_fifo || w_is_stat) || (w_is_stat && we_m2s);
    assign w_rty_c   = w_is_fifo && (we_m2s ? w_tx_full : w_rx_empty);

    always_comb begin
        w_wrap_mask = '0;
        case (bte_m2s)
            2'b01:   w_wrap_mask = ADDR_WIDTH'(3);
            2'b10:   w_wrap_mask = ADDR_WIDTH'(7);
            2'b11:   w_wrap_mask = ADDR_WIDTH'(15);
            default: w_wrap_mask = '0;
        endcase
        if (bte_m2s == 2'b00) w_inc_off = r_off + ADDR_WIDTH'(1);
        else w_inc_off = (r_off & ~w_wrap_mask) | ((r_off + ADDR_WIDTH'(1)) & w_wrap_mask);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_off   <= '0;
            r_below <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_off   <= w_next_off;
            r_below <= w_next_below;
        end
    end

    // Responses are decoded from the latched/predicted offset so burst beats need no wait state.
    always_comb begin
        w_next_state = r_state;
        w_next_off   = r_off;
        w_next_below = r_below;
        w_beat       = 1'b0;
        ack_s2m      = 1'b0;
        err_s2m      = 1'b0;
        rty_s2m      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cyc_m2s && stb_m2s) begin
                    w_next_state = S_RESP;
                    w_next_off   = w_cur_off;
                    w_next_below = w_cur_below;
                end
            end
            S_RESP: begin
                w_beat  = rst && cyc_m2s && stb_m2s;
                ack_s2m = w_beat && !w_err_c && !w_rty_c;
                err_s2m = w_beat && w_err_c;
                rty_s2m = w_beat && !w_err_c && w_rty_c;
                if (ack_s2m && (cti_m2s == 3'b001 || cti_m2s == 3'b010)) begin
                    w_next_state = S_RESP;
                    if (cti_m2s == 3'b010) w_next_off = w_inc_off;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    assign w_wr      = ack_s2m && we_m2s;
    assign w_tx_push = w_wr && !w_cur_below && (w_cur_off == FIFO_OFF);
    assign w_rx_pop  = ack_s2m && !we_m2s && w_is_fifo;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < NUM_REGS; k++) r_cfg[k] <= '0;
        end else if (w_wr && !w_cur_below) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (w_cur_off == ADDR_WIDTH'(k)) r_cfg[k] <= dat_m2s;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_cfg
        assign cfg_o[g*DATA_WIDTH +: DATA_WIDTH] = r_cfg[g];
    end

    always_comb begin
        w_status        = '0;
        w_status[0]     = w_tx_full;
        w_status[1]     = w_tx_empty;
        w_status[2]     = w_rx_full;
        w_status[3]     = w_rx_empty;
        w_status[15:8]  = 8'(w_tx_count);
        w_status[23:16] = 8'(w_rx_count);
    end

    always_comb begin
        dat_s2m = '0;
        if (ack_s2m && !we_m2s) begin
            if (w_is_fifo) dat_s2m = w_rx_head;
            else if (w_is_stat) dat_s2m = w_status;
            else begin
                for (int k = 0; k < NUM_REGS; k++) begin
                    if (r_off == ADDR_WIDTH'(k)) dat_s2m = r_cfg[k];
                end
            end
        end
    end

    assign tx_valid = !w_tx_empty;
    assign rx_ready = !w_rx_full;

    wb_burst_slave_fifo #(.DW(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_tx_push),
        .i_dat   (dat_m2s),
        .i_pop   (tx_valid && tx_ready),
        .o_head  (tx_dat),
        .o_count (w_tx_count),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty)
    );

    wb_burst_slave_fifo #(.DW(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (rx_valid && rx_ready),
        .i_dat   (rx_dat),
        .i_pop   (w_rx_pop),
        .o_head  (w_rx_head),
        .o_count (w_rx_count),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty)
    );
endmodule

// File: doc/wb_burst_slave.md
# wb_burst_slave

Parametrised Wishbone B4 slave for the SDIO controller. It adds registered-feedback bursts (CTI/BTE), error and retry signalling, a configurable register bank, and two FIFO windows to the single-beat register slave. It sits between the system Wishbone bus and the SDIO core: configuration registers drive the core, the TX FIFO feeds the card data path, and the RX FIFO collects card data.

## Interface
- ADDR_WIDTH, 32, bus address width
- DATA_WIDTH, 32, bus data width (32 or 64)
- BASE_ADDRESS, 32'h0, byte address of word offset 0
- NUM_REGS, 8, number of R/W config registers (1..64)
- FIFO_DEPTH, 16, entries per FIFO (power of two, 2..128)

- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low (sampled on rising clk)
- adr_m2s  in  ADDR_WIDTH  byte address
- dat_m2s  in  DATA_WIDTH  write data
- dat_s2m  out  DATA_WIDTH  read data, valid while ack_s2m=1
- we_m2s, cyc_m2s, stb_m2s  in  1  Wishbone write, cycle, strobe
- cti_m2s  in  3  cycle type: 000 classic, 001 constant burst, 010 incrementing, 111 end-of-burst
- bte_m2s  in  2  burst type: 00 linear, 01 wrap-4, 10 wrap-8, 11 wrap-16
- ack_s2m, err_s2m, rty_s2m  out  1  response strobes, mutually exclusive
- cfg_o  out  NUM_REGS*DATA_WIDTH  flat config register image; reg k is at bits [k*DATA_WIDTH +: DATA_WIDTH]
- tx_dat  out  DATA_WIDTH; tx_valid out 1; tx_ready in 1  TX FIFO head toward the core
- rx_dat  in  DATA_WIDTH; rx_valid in 1; rx_ready out 1  RX FIFO input from the core

## Operation
- Word offset = (adr_m2s − BASE_ADDRESS) >> log2(DATA_WIDTH/8). Offsets 0..NUM_REGS−1 are the R/W config regs. Offset NUM_REGS is the FIFO port: a write pushes TX, a read pops RX. Offset NUM_REGS+1 is STATUS (read-only). Any other offset, including one below the base, is unmapped.
- STATUS layout: [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty, [15:8] tx_count, [23:16] rx_count, all other bits 0.
- Each beat gets exactly one response:
  - err: unmapped offset, or a write to STATUS.
  - rty: write to the FIFO port while TX is full, or read from it while RX is empty.
  - ack: every other beat.
- A write commits only on a clock edge where cyc, stb, we and ack are all 1. A FIFO pop happens only on an edge where ack=1 and we=0 at the FIFO port. err and rty have no side effects.
- FSM states:
  - IDLE → RESP when cyc & stb.
  - RESP → RESP if the beat was acked, cyc & stb are still 1, and cti is 001 or 010.
  - RESP → IDLE otherwise: classic cycle, cti=111, err/rty issued, or stb/cyc low.
- Burst address prediction: cti=001 keeps the offset. cti=010 increments the word offset, wrapping inside the aligned 4/8/16-word block per bte. The predicted offset supplies read data and the response for the next beat. Writes always use adr_m2s of the committing edge.
- TX/RX FIFOs: circular buffers with count width log2(FIFO_DEPTH)+1.
  - tx_valid = !tx_empty; tx_dat is the TX head; a TX pop occurs on tx_valid & tx_ready.
  - rx_ready = !rx_full; an RX push occurs on rx_valid & rx_ready.
  - A simultaneous push and pop leaves the count unchanged. Pushing into a full FIFO or popping an empty one is impossible by construction.

## Timing
- Reset (rst=0 at a rising edge): ack/err/rty=0, dat_s2m=0, all cfg regs=0, both FIFOs empty (tx_valid=0, rx_ready=1), FSM=IDLE. Reset mid-burst aborts it with no further commit.
- Classic cycle: response is asserted in the cycle after cyc & stb is first sampled, for exactly one cycle, and is followed by at least one cycle with no response. Throughput is one beat per 2 cycles.
- Burst (cti 001/010): first beat responds 1 cycle after stb. Each later beat is acked in consecutive cycles with zero wait states. The beat carrying cti=111 is the last one; ack drops the cycle after it.
- err/rty terminate a burst: the response is a one-cycle pulse, then IDLE. The master restarts from the failing address.
- cyc or stb dropping mid-burst: no response and no commit in that cycle; FSM is IDLE next cycle.
- RX-empty and TX-full for a burst beat are evaluated against the count after that cycle's own pop/push, so the beat after the last available entry gets rty.
- dat_s2m is 0 whenever no ack is asserted.

## Test plan
- Reset then classic write 32'hA5A5_0001 to offset 2, read offset 2 → ack one cycle after stb each time, dat_s2m=32'hA5A5_0001, cfg_o reg 2 updated on the commit edge.
- Incrementing burst, bte=01, start at offset 2, 4 writes of 1..4, last beat cti=111 → 4 consecutive ack cycles. Reads return reg2=1, reg3=2, reg0=3, reg1=4 (wrap-4). ack low the cycle after the 111 beat.
- Constant burst of 17 writes to the FIFO port with FIFO_DEPTH=16 and tx_ready=0 → 16 acks, the 17th beat gets rty. STATUS reads tx_full=1, tx_count=16.
- Drive rx_valid with 3 words, then constant-burst read 4 beats from the FIFO port → 3 acks with data in order, 4th beat rty. STATUS then reads rx_empty=1, rx_count=0.
- Read offset NUM_REGS+2, then write STATUS → err pulse for 1 cycle each, no ack, cfg_o and FIFOs unchanged.
- Assert rst=0 mid-burst at beat 2 of 4 → next cycle all responses are 0, cfg_o=0, FIFOs empty, and a new classic read of offset 0 returns 0.
